// File: rtl/store_buffer_pkg.sv
// Shared types for the MEM-stage store buffer.
// Holds store encodings, the full-word byte-enable mask and the entry layout.
package store_buffer_pkg;

    // Store width encodings used by the writeback/store hop.
    typedef enum logic [1:0] {
        WB_WORD = 2'b00,
        WB_BYTE = 2'b01
    } wbhop_e;

    localparam logic [3:0] BE_WORD = 4'b1111;

    // One buffered store; the address is kept at word granularity.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match selector for store buffer load lookups.
// Ports: valid/addr/be vectors and tail in; hit, index, coverage, conflict out.
module sb_match #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]       valid_i,
    input  logic [DEPTH-1:0][29:0] addr_i,
    input  logic [DEPTH-1:0][3:0]  be_i,
    input  logic [PW-1:0]          tail_i,
    input  logic [29:0]            ld_addr_i,
    input  logic [3:0]             ld_be_i,
    output logic                   hit_o,
    output logic [PW-1:0]          idx_o,
    output logic                   cov_o,
    output logic                   conflict_o
);

    logic [PW-1:0] j;

    // Walk from oldest (tail - DEPTH) to youngest (tail - 1);
    // the last match seen is therefore the youngest one.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        j     = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            j = tail_i - PW'(k);
            if (valid_i[j] && (addr_i[j] == ld_addr_i)) begin
                hit_o = 1'b1;
                idx_o = j;
            end
        end
    end

    assign cov_o      = hit_o && ((be_i[idx_o] & ld_be_i) == ld_be_i);
    assign conflict_o = hit_o && !cov_o;

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between EX/MEM and the data memory write port.
// Ports: store in (st_*), load lookup (ld_*), DM write out (dm_*), flags.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_pc,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_be,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_be,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic        ld_stall,
    input  logic        dm_busy,
    output logic        dm_we,
    output logic [31:0] dm_pc,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [3:0]  dm_be,
    output logic        empty,
    output logic        full
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0] entry_q, entry_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic push, pop;
    logic ld_act;
    logic unused_addr_lsb;

    logic [DEPTH-1:0]       v_vec;
    logic [DEPTH-1:0][29:0] a_vec;
    logic [DEPTH-1:0][3:0]  b_vec;
    logic                   m_hit, m_cov, m_conf;
    logic [PW-1:0]          m_idx;

    assign unused_addr_lsb = ^{st_addr[1:0], ld_addr[1:0], m_hit};

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));

    // Gated by reset so pending entries never reach DM on the reset edge.
    assign dm_we    = reset && !empty && !dm_busy;
    assign st_ready = !full || dm_we;
    assign push     = st_valid && st_ready;
    assign pop      = dm_we;

    assign dm_pc   = entry_q[head_q].pc;
    assign dm_addr = {entry_q[head_q].waddr, 2'b00};
    assign dm_wd   = entry_q[head_q].data;
    assign dm_be   = entry_q[head_q].be;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            v_vec[i] = entry_q[i].valid;
            a_vec[i] = entry_q[i].waddr;
            b_vec[i] = entry_q[i].be;
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_match (
        .valid_i    (v_vec),
        .addr_i     (a_vec),
        .be_i       (b_vec),
        .tail_i     (tail_q),
        .ld_addr_i  (ld_addr[31:2]),
        .ld_be_i    (ld_be),
        .hit_o      (m_hit),
        .idx_o      (m_idx),
        .cov_o      (m_cov),
        .conflict_o (m_conf)
    );

    // A store presented alongside a load wins; the load result is masked.
    assign ld_act   = ld_valid && !st_valid;
    assign ld_hit   = ld_act && m_cov;
    assign ld_data  = ld_hit ? entry_q[m_idx].data : 32'h0;
    assign ld_stall = (st_valid && !st_ready) || (ld_act && m_conf);

    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Clear before set: on a full push+pop head equals tail.
        if (pop) begin
            entry_d[head_q].valid = 1'b0;
            head_d = head_q + PW'(1);
        end
        if (push) begin
            entry_d[tail_q].valid = 1'b1;
            entry_d[tail_q].pc    = st_pc;
            entry_d[tail_q].waddr = st_addr[31:2];
            entry_d[tail_q].data  = st_data;
            entry_d[tail_q].be    = st_be;
            tail_d = tail_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Drives inputs 1ns after each rising edge and checks 1ns later.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_pc;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        dm_busy;
    logic        dm_we;
    logic [31:0] dm_pc;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic        empty;
    logic        full;

    int n_tests;
    int n_fail;

    store_buffer #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_pc    (st_pc),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_be    (st_be),
        .st_ready (st_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_be    (ld_be),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .ld_stall (ld_stall),
        .dm_busy  (dm_busy),
        .dm_we    (dm_we),
        .dm_pc    (dm_pc),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .dm_be    (dm_be),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic store(input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_pc    = pc;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        st_valid = 1'b0;
        st_pc    = '0;
        st_addr  = '0;
        st_data  = '0;
        st_be    = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_be    = '0;
        dm_busy  = 1'b1;

        // Initial reset and reset-state checks
        tick();
        tick();
        settle();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_ld_hit", 32'(ld_hit), 32'd0);
        chk("rst_ld_stall", 32'(ld_stall), 32'd0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_dm_wd", dm_wd, 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_pc", dm_pc, 32'h0);

        // Three pending stores, then reset while DM is free
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            store(32'h0000_0800 + 32'(4 * i), 32'h100 + 32'(4 * i),
                  32'hC000_0000 + 32'(i), 4'hF);
            tick();
        end
        st_valid = 1'b0;
        settle();
        chk("pend_empty", 32'(empty), 32'd0);
        chk("pend_full", 32'(full), 32'd0);
        dm_busy = 1'b0;
        reset   = 1'b0;
        settle();
        chk("rst_edge_dm_we", 32'(dm_we), 32'd0);
        tick();
        chk("rst1_empty", 32'(empty), 32'd1);
        chk("rst1_dm_we", 32'(dm_we), 32'd0);
        tick();
        chk("rst2_empty", 32'(empty), 32'd1);
        chk("rst2_dm_we", 32'(dm_we), 32'd0);
        reset = 1'b1;
        settle();
        chk("post_st_ready", 32'(st_ready), 32'd1);
        chk("post_ld_hit", 32'(ld_hit), 32'd0);
        chk("post_ld_stall", 32'(ld_stall), 32'd0);

        // Single sw drains the next cycle
        store(32'h0000_1000, 32'h10, 32'h1234_5678, 4'hF);
        settle();
        chk("sw_ready", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        settle();
        chk("sw_dm_we", 32'(dm_we), 32'd1);
        chk("sw_dm_addr", dm_addr, 32'h10);
        chk("sw_dm_wd", dm_wd, 32'h1234_5678);
        chk("sw_dm_be", 32'(dm_be), 32'hF);
        chk("sw_dm_pc", dm_pc, 32'h0000_1000);
        tick();
        chk("sw_drained", 32'(empty), 32'd1);
        chk("sw_dm_we_off", 32'(dm_we), 32'd0);

        // Fill with DM busy, fifth store blocked
        dm_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            store(32'h0000_2000 + 32'(4 * i), 32'h200 + 32'(4 * i),
                  32'hD000_0000 + 32'(i), 4'hF);
            settle();
            chk("fill_ready", 32'(st_ready), 32'd1);
            tick();
        end
        store(32'h0000_2010, 32'h210, 32'hD000_0004, 4'hF);
        settle();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill5_ready", 32'(st_ready), 32'd0);
        chk("fill5_stall", 32'(ld_stall), 32'd1);
        tick();
        chk("fill5_ready_hold", 32'(st_ready), 32'd0);
        dm_busy = 1'b0;
        settle();
        chk("rel_dm_we", 32'(dm_we), 32'd1);
        chk("rel_ready", 32'(st_ready), 32'd1);
        chk("rel_stall", 32'(ld_stall), 32'd0);
        chk("rel_dm_wd0", dm_wd, 32'hD000_0000);
        tick();
        st_valid = 1'b0;
        settle();
        chk("rel_full_kept", 32'(full), 32'd1);
        for (int i = 1; i < 5; i++) begin
            chk("order_we", 32'(dm_we), 32'd1);
            chk("order_wd", dm_wd, 32'hD000_0000 + 32'(i));
            chk("order_addr", dm_addr, 32'h200 + 32'(4 * i));
            tick();
        end
        chk("order_empty", 32'(empty), 32'd1);

        // Youngest of two same-address stores forwards
        dm_busy = 1'b1;
        store(32'h0000_3000, 32'h20, 32'hAAAA_AAAA, 4'hF);
        tick();
        store(32'h0000_3004, 32'h20, 32'hBBBB_BBBB, 4'hF);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h20;
        ld_be    = 4'hF;
        settle();
        chk("fwd_hit", 32'(ld_hit), 32'd1);
        chk("fwd_data", ld_data, 32'hBBBB_BBBB);
        chk("fwd_stall", 32'(ld_stall), 32'd0);
        store(32'h0000_3008, 32'h50, 32'h5555_5555, 4'hF);
        settle();
        chk("both_hit", 32'(ld_hit), 32'd0);
        chk("both_stall", 32'(ld_stall), 32'd0);
        st_valid = 1'b0;
        ld_valid = 1'b0;
        dm_busy  = 1'b0;
        tick();
        tick();
        chk("fwd_drained", 32'(empty), 32'd1);

        // Partial overlap stalls until the sb drains
        dm_busy = 1'b1;
        store(32'h0000_4000, 32'h31, 32'h0000_CD00, 4'b0010);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h30;
        ld_be    = 4'hF;
        settle();
        chk("part_stall1", 32'(ld_stall), 32'd1);
        chk("part_hit1", 32'(ld_hit), 32'd0);
        tick();
        chk("part_stall2", 32'(ld_stall), 32'd1);
        dm_busy = 1'b0;
        settle();
        chk("part_dm_we", 32'(dm_we), 32'd1);
        chk("part_dm_addr", dm_addr, 32'h30);
        chk("part_dm_be", 32'(dm_be), 32'h2);
        tick();
        chk("part_stall_off", 32'(ld_stall), 32'd0);
        chk("part_hit_off", 32'(ld_hit), 32'd0);
        ld_valid = 1'b0;

        // Byte load fully covered by a byte store forwards
        dm_busy = 1'b1;
        store(32'h0000_5000, 32'h31, 32'h0000_CD00, 4'b0010);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h31;
        ld_be    = 4'b0010;
        settle();
        chk("lb_hit", 32'(ld_hit), 32'd1);
        chk("lb_data", ld_data, 32'h0000_CD00);
        chk("lb_stall", 32'(ld_stall), 32'd0);

        // Load with no matching entry
        ld_addr = 32'h40;
        ld_be   = 4'hF;
        settle();
        chk("miss_hit", 32'(ld_hit), 32'd0);
        chk("miss_stall", 32'(ld_stall), 32'd0);
        chk("miss_data", ld_data, 32'h0);
        ld_valid = 1'b0;
        dm_busy  = 1'b0;
        tick();
        chk("final_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Four-entry FIFO store buffer between the EX/MEM pipeline register and the data memory write port. MEM-stage stores retire into the buffer in one cycle, and the buffer drains them to DM one per cycle while DM is free. Loads check the buffer first: a full-coverage word match is forwarded, and a partial overlap stalls the pipeline until the entry drains. This keeps program-order memory semantics and the DM write `$display` trace (pc, word address, data) identical to an unbuffered design.

## Interface
- `DEPTH`, 4, number of entries; must be a power of two, at least 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; 0 on a rising edge clears the buffer.
- `st_valid`  in  1  a MEM-stage store is presented this cycle.
- `st_pc`  in  32  PC of the store, carried to DM for the trace.
- `st_addr`  in  32  byte address; bits [1:0] are ignored for the match (word granularity).
- `st_data`  in  32  write data, already lane-aligned (sb data replicated in its byte lane).
- `st_be`  in  4  byte enables; 4'b1111 for sw, one-hot for sb.
- `st_ready`  out  1  the store is accepted this cycle.
- `ld_valid`  in  1  a MEM-stage load is presented this cycle.
- `ld_addr`  in  32  load byte address.
- `ld_be`  in  4  bytes the load needs.
- `ld_hit`  out  1  forwarded data is valid; the pipeline uses `ld_data` instead of DM RD.
- `ld_data`  out  32  forwarded word.
- `ld_stall`  out  1  freeze IF–MEM this cycle.
- `dm_busy`  in  1  DM write port is unavailable this cycle.
- `dm_we`  out  1  DM write strobe.
- `dm_pc`, `dm_addr`, `dm_wd`  out  32 each  head entry fields; `dm_addr` is the word address with [1:0]=0.
- `dm_be`  out  4  head entry byte enables.
- `empty`, `full`  out  1 each  occupancy flags.

## Operation
- Each entry stores {valid, pc, word addr[31:2], data, be}. Pointers `head` and `tail` are log2(DEPTH) bits wide, plus a `count` of 0..DEPTH.
- **Push:** when `st_valid & st_ready`, write the entry at `tail` and advance `tail` modulo DEPTH.
- **Pop:** `dm_we = !empty & !dm_busy`. When `dm_we` is high, the head entry is written to DM this edge and `head` advances.
- **st_ready:** `!full | dm_we`. A push into a full buffer is legal in the same cycle as a pop. `count` is unchanged on a simultaneous push and pop.
- **Store stall:** when `st_valid & !st_ready`, assert `ld_stall`; the store is re-presented next cycle.
- **Load lookup:** compare `ld_addr[31:2]` against every valid entry and select the youngest match (closest to `tail`).
  - Youngest match has `(be & ld_be) == ld_be`: `ld_hit=1`, `ld_data` = that entry's data.
  - Any valid match whose bytes are not all covered by the youngest matching entry: `ld_stall=1`, `ld_hit=0`. Re-evaluated every cycle until resolved.
  - No match: `ld_hit=0`, `ld_stall=0`, and the load reads DM normally.
- The entry being popped in the current cycle still participates in the lookup. Its DM write lands at the same edge, so forwarding remains correct.
- **Simultaneous store and load:** the MEM stage never presents both in one cycle. If it does, the store takes priority and `ld_hit` and `ld_stall` are forced to 0.
- **Reset:** `count=0`, head and tail at 0, all entries invalid. After reset: `dm_we=0`, `st_ready=1`, `ld_hit=0`, `ld_stall=0`, `empty=1`, `full=0`, `ld_data=0`, and dm data outputs 0.
- A reset that arrives while entries are pending discards them; no DM write occurs on the reset edge.

## Timing
- **Store acceptance:** zero-cycle decision; the entry is visible to the lookup from the next cycle.
- **Drain:** the earliest DM write is the edge after push. With `dm_busy=0`, a store reaches DM one cycle after acceptance, and back-to-back stores drain one per cycle.
- **Outputs:** `ld_hit`, `ld_data` and `ld_stall` are combinational from registered state and the current load inputs. `dm_*` outputs are combinational from the head entry and `dm_busy`.
- **Partial-overlap stall:** lasts until the conflicting entries drain, at most DEPTH cycles with `dm_busy=0`.

## Structure
- Shared package holds the WBHop store encodings (word=2'b00, byte=2'b01), a `BE_WORD` constant of 4'b1111, and the entry struct.
- One natural sub-module, `sb_match`: a combinational youngest-match priority selector taking the valid, address and be vectors plus `tail`. It returns the hit index, coverage bit and conflict bit.

## Test plan
- Reset low for 2 cycles with 3 entries pending:
  - Required: `empty=1` and no `dm_we` during reset.
  - Required: after reset, `st_ready=1`, `ld_hit=0`, `ld_stall=0`.
- sw 0x0000_0010 ← 0x1234_5678 with `dm_busy=0`:
  - Required: `dm_we=1` next cycle, `dm_addr=0x10`, `dm_wd=0x12345678`, `dm_be=4'hF`.
- Hold `dm_busy=1` and issue 5 sw:
  - Required: `full=1` after the 4th, and `st_ready=0` plus `ld_stall=1` on the 5th.
  - Then release `dm_busy`. Required: the 5th is accepted on the same cycle as the first pop, and the order seen at DM matches issue order.
- sw 0x20 ← 0xAAAA_AAAA, then sw 0x20 ← 0xBBBB_BBBB, then lw 0x20 with `dm_busy=1`:
  - Required: `ld_hit=1`, `ld_data=0xBBBBBBBB` (youngest entry wins).
- sb 0x31 (be 4'b0010), then lw 0x30 with `dm_busy=1` for 2 cycles, then release `dm_busy`:
  - Required: `ld_stall=1` for the 2 busy cycles.
  - Required: on release, the drain occurs, and the next cycle has `ld_stall=0` and `ld_hit=0` (the load reads DM).
- lw 0x40 with no matching entry:
  - Required: `ld_hit=0` and `ld_stall=0`.
